// File: rtl/ad9228_pkg.sv
// Shared definitions for the AD9228 serial interface (transmit emulator and receive side).
// Build option AD9228_TX_RAMP_EN enables the per-lane test ramp in ad9228_lvds_tx.
package ad9228_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } tx_state_t;

    localparam int          DATA_WIDTH_DEF   = 12;
    localparam int          NUM_CHANNELS_DEF = 4;
    localparam logic [11:0] SYNC_PATTERN_DEF = 12'hA5C;
    localparam logic [11:0] IDLE_PATTERN_DEF = 12'h800;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ad9228_lane_ser.sv
// One AD9228 data lane: parallel-load shift register sending MSB first, with optional
// output inversion. Loading takes priority over shifting.
module ad9228_lane_ser
    import ad9228_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit INVERT     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  din_o
);

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign din_o = shreg_q[DATA_WIDTH-1] ^ INVERT;

endmodule

// File: rtl/ad9228_lvds_tx.sv
// AD9228 serial output emulator: FSM, framing (fco/dco), sample handshake and underrun tracking.
// Define AD9228_TX_RAMP_EN to add the test_ramp input and per-lane ramp generator.
module ad9228_lvds_tx
    import ad9228_pkg::*;
#(
    parameter int                    NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int                    SYNC_FRAMES  = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = DATA_WIDTH'(SYNC_PATTERN_DEF),
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = DATA_WIDTH'(IDLE_PATTERN_DEF),
    parameter bit                    DIN_INVERTED = 1'b0,
    parameter bit                    DCO_INVERTED = 1'b0,
    parameter bit                    FCO_INVERTED = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   tx_en,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] s_data,
`ifdef AD9228_TX_RAMP_EN
    input  logic                                   test_ramp,
`endif
    output logic [NUM_CHANNELS-1:0]                din,
    output logic                                   fco,
    output logic                                   dco,
    output logic                                   busy,
    output logic                                   underrun,
    output logic [15:0]                            underrun_cnt
);

    localparam int               CNT_W     = $clog2(DATA_WIDTH);
    localparam int               FRM_W     = $clog2(SYNC_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(DATA_WIDTH / 2);
    localparam logic [FRM_W-1:0] LAST_SYNC = FRM_W'(SYNC_FRAMES - 1);

    tx_state_t                              state_q, state_d;
    logic [CNT_W-1:0]                       bit_cnt_q, bit_cnt_d;
    logic [FRM_W-1:0]                       frame_cnt_q, frame_cnt_d;
    logic                                   fco_q, fco_d;
    logic                                   dco_q, dco_d;
    logic                                   busy_q;
    logic                                   underrun_q;
    logic [15:0]                            underrun_cnt_q;

    logic                                   last_bit;
    logic                                   stream_slot;
    logic                                   take_underrun;
    logic                                   ramp_sel;
    logic                                   lane_load;
    logic                                   lane_shift;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] lane_word;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ramp_word;

    assign last_bit    = (bit_cnt_q == LAST_BIT);
    // The final SYNC frame already behaves as a STREAM frame for the handshake.
    assign stream_slot = (state_q == STREAM) || ((state_q == SYNC) && (frame_cnt_q == LAST_SYNC));

    assign s_ready       = tx_en && last_bit && stream_slot && !ramp_sel;
    assign take_underrun = s_ready && !s_valid;

`ifdef AD9228_TX_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic                  ramp_load;

    assign ramp_sel  = test_ramp;
    assign ramp_load = test_ramp && tx_en && last_bit && stream_slot;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ramp_word[i] = ramp_q + DATA_WIDTH'(i);
        end
    end

    always_comb begin
        ramp_d = ramp_q;
        if (state_q == IDLE) begin
            ramp_d = '0;
        end else if (ramp_load) begin
            ramp_d = ramp_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    assign ramp_sel  = 1'b0;
    assign ramp_word = '0;
`endif

    // Every frame boundary reloads the lanes so that bit_cnt = 0 always shows a word MSB;
    // returning to IDLE loads zeros so din rests at its reset value.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lane_load   = 1'b0;
        lane_shift  = 1'b0;
        lane_word   = '0;
        unique case (state_q)
            IDLE: begin
                if (tx_en) begin
                    state_d     = SYNC;
                    frame_cnt_d = '0;
                    lane_load   = 1'b1;
                    lane_word   = {NUM_CHANNELS{SYNC_PATTERN}};
                end
            end
            SYNC, STREAM: begin
                if (!last_bit) begin
                    lane_shift = 1'b1;
                    if (!tx_en) begin
                        state_d = DRAIN;
                    end
                end else if (!tx_en) begin
                    state_d   = IDLE;
                    lane_load = 1'b1;
                end else if (!stream_slot) begin
                    frame_cnt_d = frame_cnt_q + FRM_W'(1);
                    lane_load   = 1'b1;
                    lane_word   = {NUM_CHANNELS{SYNC_PATTERN}};
                end else begin
                    state_d   = STREAM;
                    lane_load = 1'b1;
                    if (ramp_sel) begin
                        lane_word = ramp_word;
                    end else if (s_valid) begin
                        lane_word = s_data;
                    end else begin
                        lane_word = {NUM_CHANNELS{IDLE_PATTERN}};
                    end
                end
            end
            DRAIN: begin
                if (last_bit) begin
                    state_d   = IDLE;
                    lane_load = 1'b1;
                end else begin
                    lane_shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if ((state_q == IDLE) || (state_d == IDLE) || last_bit) begin
            bit_cnt_d = '0;
        end
        fco_d = (state_d != IDLE) && (bit_cnt_d < HALF_BIT);
        dco_d = (state_d != IDLE) ? ~dco_q : 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            fco_q          <= 1'b0;
            dco_q          <= 1'b0;
            busy_q         <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fco_q       <= fco_d;
            dco_q       <= dco_d;
            busy_q      <= (state_d != IDLE);
            if (take_underrun) begin
                underrun_q     <= 1'b1;
                underrun_cnt_q <= sat_inc16(underrun_cnt_q);
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        ad9228_lane_ser #(
            .DATA_WIDTH (DATA_WIDTH),
            .INVERT     (DIN_INVERTED)
        ) u_lane (
            .clk_i   (clk),
            .rst_n_i (rstn),
            .load_i  (lane_load),
            .shift_i (lane_shift),
            .data_i  (lane_word[i]),
            .din_o   (din[i])
        );
    end

    assign fco          = fco_q ^ FCO_INVERTED;
    assign dco          = dco_q ^ DCO_INVERTED;
    assign busy         = busy_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_ad9228_lvds_tx.sv
// Directed bench for ad9228_lvds_tx (default parameters): reset, sync, stream, underrun,
// drain with tx_en re-rise, and asynchronous reset mid-frame.
module tb_ad9228_lvds_tx;

    localparam int NC = 4;
    localparam int DW = 12;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   txEn;
    logic                   sValid;
    logic                   sReady;
    logic [NC-1:0][DW-1:0]  sData;
    logic [NC-1:0]          din;
    logic                   fco;
    logic                   dco;
    logic                   busy;
    logic                   underrun;
    logic [15:0]            underrunCnt;
`ifdef AD9228_TX_RAMP_EN
    logic                   testRamp = 1'b0;
`endif

    int testCount = 0;
    int failCount = 0;

    localparam logic [NC-1:0][DW-1:0] W1 = {12'hABC, 12'h789, 12'h456, 12'h123};
    localparam logic [NC-1:0][DW-1:0] W2 = {12'hCBA, 12'h987, 12'h654, 12'h321};
    localparam logic [NC-1:0][DW-1:0] W3 = {12'h0FF, 12'h1E0, 12'h2D4, 12'h3C5};
    localparam logic [NC-1:0][DW-1:0] SYNCW = {4{12'hA5C}};
    localparam logic [NC-1:0][DW-1:0] IDLEW = {4{12'h800}};

    ad9228_lvds_tx dut (
        .clk          (clk),
        .rstn         (rstn),
        .tx_en        (txEn),
        .s_valid      (sValid),
        .s_ready      (sReady),
        .s_data       (sData),
`ifdef AD9228_TX_RAMP_EN
        .test_ramp    (testRamp),
`endif
        .din          (din),
        .fco          (fco),
        .dco          (dco),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrunCnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [NC-1:0][DW-1:0] data);
        txEn   = en;
        sValid = valid;
        sData  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Records one whole frame starting at bit 0; tx_en can be dropped/raised at given bit positions.
    task automatic captureFrame(input int dropAt, input int riseAt,
                                output logic [NC-1:0][DW-1:0] words,
                                output logic [DW-1:0] fcoPat,
                                output logic [DW-1:0] dcoPat,
                                output logic [DW-1:0] readyMask);
        for (int b = 0; b < DW; b++) begin
            if (b == dropAt) txEn = 1'b0;
            if (b == riseAt) txEn = 1'b1;
            for (int l = 0; l < NC; l++) begin
                words[l][DW-1-b] = din[l];
            end
            fcoPat[DW-1-b] = fco;
            dcoPat[DW-1-b] = dco;
            readyMask[b]   = sReady;
            tick();
        end
    endtask

    initial begin
        logic [NC-1:0][DW-1:0] words;
        logic [DW-1:0]         fcoPat;
        logic [DW-1:0]         dcoPat;
        logic [DW-1:0]         rdy;
        logic [DW-1:0]         readyEarly;
        int                    badSync;

        applyStimulus(1'b0, 1'b0, '0);
        rstn = 1'b0;
        repeat (2) tick();
        checkOutput("reset_din", din, 4'h0);
        checkOutput("reset_fco_dco", {fco, dco}, 2'b00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ready", sReady, 1'b0);
        checkOutput("reset_underrun", {underrun, underrunCnt}, 17'h0);

        rstn = 1'b1;
        repeat (3) tick();
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_din", din, 4'h0);

        // s_valid high during SYNC must not be consumed early
        applyStimulus(1'b1, 1'b1, W1);
        tick();
        checkOutput("sync_busy", busy, 1'b1);
        checkOutput("sync_first_msb", din, 4'hF);

        badSync    = 0;
        readyEarly = '0;
        for (int f = 0; f < 16; f++) begin
            captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
            if (words !== SYNCW) badSync++;
            if (f == 0) begin
                checkOutput("sync_fco_pattern", fcoPat, 12'hFC0);
                checkOutput("sync_dco_pattern", dcoPat, 12'hAAA);
            end
            if (f < 15) readyEarly = readyEarly | rdy;
            else        checkOutput("sync_last_ready", rdy, 12'h800);
        end
        checkOutput("sync_frames", badSync, 0);
        checkOutput("sync_no_early_ready", readyEarly, 12'h000);

        applyStimulus(1'b1, 1'b1, W2);
        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("stream_w1", words, W1);
        checkOutput("stream_ready", rdy, 12'h800);
        checkOutput("stream_fco", fcoPat, 12'hFC0);

        applyStimulus(1'b1, 1'b0, W2);
        checkOutput("no_underrun_yet", underrun, 1'b0);
        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("stream_w2", words, W2);
        checkOutput("underrun_set", underrun, 1'b1);
        checkOutput("underrun_cnt_1", underrunCnt, 16'd1);

        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("idle_frame_1", words, IDLEW);
        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("idle_frame_2", words, IDLEW);
        applyStimulus(1'b1, 1'b1, W3);
        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("idle_frame_3", words, IDLEW);
        checkOutput("underrun_cnt_3", underrunCnt, 16'd3);
        captureFrame(-1, -1, words, fcoPat, dcoPat, rdy);
        checkOutput("stream_resume", words, W3);

        // tx_en falls at bit 4 and rises again at bit 7: frame completes, then IDLE, then SYNC
        captureFrame(4, 7, words, fcoPat, dcoPat, rdy);
        checkOutput("drain_full_frame", words, W3);
        checkOutput("drain_no_ready", rdy, 12'h000);
        checkOutput("drain_dco", dcoPat, 12'hAAA);
        checkOutput("drain_idle_busy", busy, 1'b0);
        checkOutput("drain_idle_outs", {din, fco, dco}, 6'h00);
        tick();
        checkOutput("resync_busy", busy, 1'b1);
        checkOutput("resync_msb", din, 4'hF);
        checkOutput("underrun_sticky", {underrun, underrunCnt}, {1'b1, 16'd3});

        repeat (5) tick();
        checkOutput("midframe_din", din, 4'hF);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_din", din, 4'h0);
        checkOutput("async_reset_ctrl", {fco, dco, busy}, 3'b000);
        checkOutput("async_reset_underrun", {underrun, underrunCnt}, 17'h0);

        applyStimulus(1'b0, 1'b0, '0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        checkOutput("post_reset_busy", busy, 1'b0);
        checkOutput("post_reset_ready", sReady, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
